hatch_seq_ctrl: RTL and testbench
=================================

Name: hatch_seq_ctrl

Overview:
- Stage sequencer for the egg-hatch 8x8 dot-matrix display.
- Times incubation progress on the 1 kHz system clock and advances the display stage number 0..LAST_STAGE.
- Drives the display's enable (st) and red/over-temperature flag (temp).
- Freezes progress on over-temperature or user pause, and reports completion or failure.

Parameters:
- TICKS_PER_SEC, 1000: clk cycles per second; clk is 1 kHz.
- STAGE_SEC, 5: seconds spent in each display stage.
- LAST_STAGE, 11: final stage number; the display supports 0..11.
- HEAT_LIMIT_SEC, 10: seconds of continuous HOT before FAIL; used only with TEMP_FAIL_EN.

Ports:
- clk  input  1  system clock, 1 kHz.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  single-cycle pulse, synchronous; begins or restarts a run.
- pause  input  1  single-cycle pulse, synchronous; toggles RUN/PAUSE.
- temp_hi  input  1  level; 1 = incubator over temperature.
- num  output  4  stage number to the display, 0..LAST_STAGE.
- st  output  1  display enable.
- temp  output  1  display red-overlay flag.
- done  output  1  hatch complete.
- fail  output  1  run aborted by overheat.
- state  output  3  current FSM state code, for debug and LEDs.

Behaviour:
- Reset (async, rst=1): state=IDLE, num=0, st=0, temp=0, done=0, fail=0. tick_cnt, sec_cnt and heat_cnt are cleared.
- All outputs are registered and reflect the new state in the cycle after the causing input is sampled.
- State codes: IDLE=0, RUN=1, PAUSE=2, HOT=3, DONE=4, FAIL=5. Codes 6 and 7 are unreachable and recover to IDLE on the next clk.
- tick_cnt counts 0..TICKS_PER_SEC-1 and wraps. sec_cnt counts 0..STAGE_SEC-1. Counter widths use $clog2 of their range.
- IDLE:
  - st=0.
  - start=1 -> RUN; num, tick_cnt and sec_cnt are cleared.
- RUN:
  - st=1. tick_cnt increments every cycle.
  - On tick wrap, sec_cnt increments.
  - When tick wraps and sec_cnt==STAGE_SEC-1: sec_cnt clears, then:
    - if num<LAST_STAGE, num increments;
    - if num==LAST_STAGE -> DONE.
  - Each stage therefore lasts exactly STAGE_SEC*TICKS_PER_SEC cycles.
- RUN priority within one cycle: temp_hi > pause > counting.
  - temp_hi=1 -> HOT. No counter increments that cycle.
  - Else pause=1 -> PAUSE. No counter increments that cycle.
- HOT:
  - temp=1, st=1. tick_cnt, sec_cnt and num are frozen.
  - pause and start are ignored.
  - temp_hi=0 -> RUN, resuming from the frozen counters. A stage boundary is therefore delayed, never lost or skipped.
- PAUSE:
  - st=1; counters frozen.
  - temp mirrors temp_hi (registered). temp_hi does not leave PAUSE.
  - pause=1 -> RUN. start is ignored.
- DONE:
  - done=1, st=1, num=LAST_STAGE held.
  - start=1 -> RUN from stage 0, with done cleared.
- FAIL:
  - fail=1, temp=1, st=1, num held.
  - start=1 -> RUN from stage 0, with fail and temp cleared.
  - Only start or rst leaves FAIL.
- start is honoured only in IDLE, DONE and FAIL. In RUN, PAUSE and HOT it has no effect.
- temp=0 in every state except HOT, FAIL, and PAUSE with temp_hi=1.
- rst asserted mid-run returns to IDLE immediately, with all outputs at their reset values.

Optional Feature:
- Macro: TEMP_FAIL_EN.
- Defined:
  - heat_cnt (own tick prescaler plus a seconds count) is cleared on entry to HOT and counts seconds while in HOT.
  - When heat_cnt reaches HEAT_LIMIT_SEC -> FAIL.
  - Leaving HOT before the limit discards heat_cnt.
- Not defined:
  - heat_cnt logic is absent and FAIL is unreachable; fail is tied to 0.
  - HOT persists for as long as temp_hi=1.

Test Plan:
All scenarios use TICKS_PER_SEC=4, STAGE_SEC=2, LAST_STAGE=11, HEAT_LIMIT_SEC=3, giving 8 cycles per stage.
1. Async rst mid-cycle -> all outputs 0 and state=0 immediately. After release with no start, st stays 0 indefinitely.
2. start pulse -> state=1 and st=1 next cycle. num steps 0->1 after 8 cycles, and continues one step every 8 cycles. 8 cycles after num reaches 11 -> state=4 and done=1, 96 cycles after start.
3. Run to num=3 plus 5 cycles, then temp_hi=1 for 20 cycles -> state=3, temp=1, num stays 3. Release -> num reaches 4 exactly 3 cycles after re-entering RUN.
4. temp_hi and pause asserted in the same RUN cycle -> HOT, pause ignored. After temp_hi falls, a pause pulse -> PAUSE with counters frozen. A second pause pulse -> RUN.
5. TEMP_FAIL_EN defined: temp_hi held for 12 HOT cycles -> state=5, fail=1, temp=1. Then start -> state=1, num=0, fail=0. Without TEMP_FAIL_EN, the same stimulus stays in HOT and fail remains 0.
6. start pulse during RUN at num=5 -> ignored, num keeps advancing. start in DONE -> restart at num=0 with done=0.

Source files
------------

// File: rtl/hatch_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hatch_seq_ctrl
// Brief    : Stage sequencer for the egg-hatch 8x8 display; times incubation,
//            freezes on overheat/pause. Macro TEMP_FAIL_EN enables overheat abort.
// Revision : 1.0  initial release
// ============================================================================
module hatch_seq_ctrl #(
    parameter int TICKS_PER_SEC  = 1000,
    parameter int STAGE_SEC      = 5,
    parameter int LAST_STAGE     = 11,
    parameter int HEAT_LIMIT_SEC = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_pause,
    input  logic       i_temp_hi,
    output logic [3:0] o_num,
    output logic       o_st,
    output logic       o_temp,
    output logic       o_done,
    output logic       o_fail,
    output logic [2:0] o_state
);

    localparam int c_TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int c_SEC_W  = (STAGE_SEC > 1) ? $clog2(STAGE_SEC) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_MAX = c_TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [c_SEC_W-1:0]  c_SEC_MAX  = c_SEC_W'(STAGE_SEC - 1);
    localparam logic [3:0]          c_LAST     = 4'(LAST_STAGE);

    if (TICKS_PER_SEC < 1 || STAGE_SEC < 1 || LAST_STAGE < 0 || LAST_STAGE > 15
        || HEAT_LIMIT_SEC < 1) begin : g_bad_params
        $error("hatch_seq_ctrl: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_HOT   = 3'd3,
        S_DONE  = 3'd4,
        S_FAIL  = 3'd5
    } state_t;

    state_t              r_state;
    logic [3:0]          r_num;
    logic [c_TICK_W-1:0] r_tick;
    logic [c_SEC_W-1:0]  r_sec;
    logic                r_st;
    logic                r_temp;
    logic                r_done;
    logic                r_fail;

`ifdef TEMP_FAIL_EN
    localparam int c_HEAT_W = (HEAT_LIMIT_SEC > 1) ? $clog2(HEAT_LIMIT_SEC) : 1;
    localparam logic [c_HEAT_W-1:0] c_HEAT_MAX = c_HEAT_W'(HEAT_LIMIT_SEC - 1);
    logic [c_TICK_W-1:0] r_heat_tick;
    logic [c_HEAT_W-1:0] r_heat_sec;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_num   <= '0;
            r_tick  <= '0;
            r_sec   <= '0;
            r_st    <= 1'b0;
            r_temp  <= 1'b0;
            r_done  <= 1'b0;
            r_fail  <= 1'b0;
`ifdef TEMP_FAIL_EN
            r_heat_tick <= '0;
            r_heat_sec  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (i_start) begin
                        r_state <= S_RUN;
                        r_num   <= '0;
                        r_tick  <= '0;
                        r_sec   <= '0;
                        r_st    <= 1'b1;
                        r_temp  <= 1'b0;
                        r_done  <= 1'b0;
                        r_fail  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (i_temp_hi) begin
                        r_state <= S_HOT;
                        r_temp  <= 1'b1;
`ifdef TEMP_FAIL_EN
                        r_heat_tick <= '0;
                        r_heat_sec  <= '0;
`endif
                    end else if (i_pause) begin
                        r_state <= S_PAUSE;
                    end else if (r_tick == c_TICK_MAX) begin
                        r_tick <= '0;
                        if (r_sec == c_SEC_MAX) begin
                            r_sec <= '0;
                            if (r_num == c_LAST) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_num <= r_num + 4'd1;
                            end
                        end else begin
                            r_sec <= r_sec + 1'b1;
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (i_pause) begin
                        r_state <= S_RUN;
                        r_temp  <= 1'b0;
                    end else begin
                        r_temp <= i_temp_hi;
                    end
                end
                S_HOT: begin
                    // Leaving HOT wins over the overheat limit in the same cycle.
                    if (!i_temp_hi) begin
                        r_state <= S_RUN;
                        r_temp  <= 1'b0;
                    end
`ifdef TEMP_FAIL_EN
                    else if (r_heat_tick == c_TICK_MAX) begin
                        r_heat_tick <= '0;
                        if (r_heat_sec == c_HEAT_MAX) begin
                            r_state <= S_FAIL;
                            r_fail  <= 1'b1;
                        end else begin
                            r_heat_sec <= r_heat_sec + 1'b1;
                        end
                    end else begin
                        r_heat_tick <= r_heat_tick + 1'b1;
                    end
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                    r_num   <= '0;
                    r_tick  <= '0;
                    r_sec   <= '0;
                    r_st    <= 1'b0;
                    r_temp  <= 1'b0;
                    r_done  <= 1'b0;
                    r_fail  <= 1'b0;
                end
            endcase
        end
    end

    assign o_num   = r_num;
    assign o_st    = r_st;
    assign o_temp  = r_temp;
    assign o_done  = r_done;
    assign o_fail  = r_fail;
    assign o_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_hatch_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hatch_seq_ctrl
// Brief    : Directed bench for hatch_seq_ctrl against a progress-count model.
// Revision : 1.0  initial release
// ============================================================================
module tb_hatch_seq_ctrl;

    localparam int TPS  = 4;
    localparam int SS   = 2;
    localparam int LAST = 11;
    localparam int HEAT = 3;
    localparam int CPS  = TPS * SS;
`ifdef TEMP_FAIL_EN
    localparam int HOT_HOLD = 10;
`else
    localparam int HOT_HOLD = 20;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start = 1'b0;
    logic       i_pause = 1'b0;
    logic       i_temp_hi = 1'b0;
    logic [3:0] o_num;
    logic       o_st, o_temp, o_done, o_fail;
    logic [2:0] o_state;

    int n_checks = 0;
    int n_errors = 0;

    hatch_seq_ctrl #(
        .TICKS_PER_SEC (TPS),
        .STAGE_SEC     (SS),
        .LAST_STAGE    (LAST),
        .HEAT_LIMIT_SEC(HEAT)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .i_start  (i_start),
        .i_pause  (i_pause),
        .i_temp_hi(i_temp_hi),
        .o_num    (o_num),
        .o_st     (o_st),
        .o_temp   (o_temp),
        .o_done   (o_done),
        .o_fail   (o_fail),
        .o_state  (o_state)
    );

    always #5 clk = ~clk;

    // Model: progress is the number of counting cycles since start.
    int m_state = 0;
    int m_prog  = 0;
    int m_heat  = 0;
    bit m_ptemp = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = 0; m_prog = 0; m_heat = 0; m_ptemp = 1'b0;
        end else begin
            case (m_state)
                0, 4, 5: if (i_start) begin m_state = 1; m_prog = 0; end
                1: begin
                    if (i_temp_hi) begin m_state = 3; m_heat = 0; end
                    else if (i_pause) m_state = 2;
                    else begin
                        m_prog++;
                        if (m_prog == CPS * (LAST + 1)) m_state = 4;
                    end
                end
                2: if (i_pause) m_state = 1;
                3: begin
                    if (!i_temp_hi) m_state = 1;
                    else begin
                        m_heat++;
`ifdef TEMP_FAIL_EN
                        if (m_heat == HEAT * TPS) m_state = 5;
`endif
                    end
                end
                default: m_state = 0;
            endcase
            m_ptemp = (m_state == 2) && i_temp_hi;
        end
    end

    always @(negedge clk) begin
        logic [11:0] exp_v, act_v;
        int mn;
        mn = (m_prog / CPS > LAST) ? LAST : m_prog / CPS;
        exp_v = {3'(m_state), 4'(mn), 1'(m_state != 0),
                 1'(m_state == 3 || m_state == 5 || (m_state == 2 && m_ptemp)),
                 1'(m_state == 4), 1'(m_state == 5)};
        act_v = {o_state, o_num, o_st, o_temp, o_done, o_fail};
        n_checks++;
        if (act_v !== exp_v) begin
            n_errors++;
            $display("FAIL model t=%0t got state/num/st/temp/done/fail=%h want %h",
                     $time, act_v, exp_v);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic lit(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        step(5);
        lit("idle_st", o_st, 0);
        lit("idle_state", o_state, 0);

        // full run to DONE
        i_start = 1'b1; step(1); i_start = 1'b0;
        lit("start_state", o_state, 1);
        lit("start_st", o_st, 1);
        step(7);  lit("num_before_8", o_num, 0);
        step(1);  lit("num_at_8", o_num, 1);
        step(80); lit("num_at_88", o_num, 11);
        step(7);  lit("state_at_95", o_state, 1);
        step(1);  lit("done_state", o_state, 4);
        lit("done_flag", o_done, 1);
        lit("done_num", o_num, 11);

        // restart from DONE, start ignored in RUN
        i_start = 1'b1; step(1); i_start = 1'b0;
        lit("restart_num", o_num, 0);
        lit("restart_done", o_done, 0);
        step(42); lit("num5", o_num, 5);
        i_start = 1'b1; step(1); i_start = 1'b0;
        lit("run_start_ign_state", o_state, 1);
        lit("run_start_ign_num", o_num, 5);
        step(5);  lit("num6", o_num, 6);

        // asynchronous reset mid-cycle
        #2 rst = 1'b1;
        #1 lit("async_rst", {o_state, o_num, o_st, o_temp, o_done, o_fail}, 0);
        step(1); rst = 1'b0;
        step(6);
        lit("post_rst_st", o_st, 0);

        // overheat freeze at num=3 plus 5 cycles
        i_start = 1'b1; step(1); i_start = 1'b0;
        step(29); lit("pre_hot_num", o_num, 3);
        i_temp_hi = 1'b1; step(1);
        lit("hot_state", o_state, 3);
        lit("hot_temp", o_temp, 1);
        step(HOT_HOLD - 1);
        lit("hot_hold_state", o_state, 3);
        lit("hot_hold_num", o_num, 3);
        i_temp_hi = 1'b0; step(1);
        lit("hot_exit_state", o_state, 1);
        lit("hot_exit_temp", o_temp, 0);
        step(2); lit("resume_num3", o_num, 3);
        step(1); lit("resume_num4", o_num, 4);

        // temp_hi beats pause, then pause/resume
        i_temp_hi = 1'b1; i_pause = 1'b1; step(1); i_pause = 1'b0;
        lit("prio_hot", o_state, 3);
        step(2); i_temp_hi = 1'b0; step(1);
        lit("prio_back_run", o_state, 1);
        i_pause = 1'b1; step(1); i_pause = 1'b0;
        lit("pause_state", o_state, 2);
        i_start = 1'b1; step(1); i_start = 1'b0;
        lit("pause_start_ign", o_state, 2);
        i_temp_hi = 1'b1; step(1);
        lit("pause_temp_mirror", o_temp, 1);
        lit("pause_temp_stay", o_state, 2);
        i_temp_hi = 1'b0; step(1);
        lit("pause_temp_clr", o_temp, 0);
        step(8); lit("pause_frozen_num", o_num, 4);
        i_pause = 1'b1; step(1); i_pause = 1'b0;
        lit("unpause_state", o_state, 1);
        step(7); lit("unpause_num4", o_num, 4);
        step(1); lit("unpause_num5", o_num, 5);

        // long overheat
        i_temp_hi = 1'b1; step(1);
        lit("long_hot", o_state, 3);
        step(11); lit("hot_11", o_state, 3);
        step(1);
`ifdef TEMP_FAIL_EN
        lit("fail_state", o_state, 5);
        lit("fail_flag", o_fail, 1);
        lit("fail_temp", o_temp, 1);
        lit("fail_num", o_num, 5);
`else
        lit("nofail_state", o_state, 3);
        lit("nofail_flag", o_fail, 0);
`endif
        i_temp_hi = 1'b0; step(2);
`ifdef TEMP_FAIL_EN
        lit("fail_sticky", o_state, 5);
`else
        lit("nofail_run", o_state, 1);
`endif
        i_start = 1'b1; step(1); i_start = 1'b0;
`ifdef TEMP_FAIL_EN
        lit("fail_restart_state", o_state, 1);
        lit("fail_restart_num", o_num, 0);
        lit("fail_restart_fail", o_fail, 0);
        lit("fail_restart_temp", o_temp, 0);
`else
        lit("run_start_ign2", o_num, 5);
        lit("nofail_fail0", o_fail, 0);
`endif
        step(5);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
